// File: rtl/pc_sequencer_if.sv
// Signal bundle between the program-counter sequencer and the datapath around it:
// the external pc register, the instruction register and the decode/execute stage.
interface pc_sequencer_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0] pc;
  logic            stall;
  logic            halt;
  logic            jump;
  logic            jump_abs;
  logic [BITS-1:0] target;
  logic [BITS-1:0] next_pc;
  logic            ir_we;
  logic            exec_en;
  logic            halted;
  logic            wrap;
  logic [BITS-1:0] retired;

  modport master (
    output pc, stall, halt, jump, jump_abs, target,
    input  next_pc, ir_we, exec_en, halted, wrap, retired
  );

  modport slave (
    input  pc, stall, halt, jump, jump_abs, target,
    output next_pc, ir_we, exec_en, halted, wrap, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Reset/fetch/execute/halt controller that drives next_pc of a free-running pc
// register, resolves increments, absolute jumps and relative branches, and counts retirements.
module pc_sequencer #(
  parameter int              BITS     = 8,
  parameter logic [BITS-1:0] RESET_PC = {BITS{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BITS-1:0] r_retired;
  logic [BITS-1:0] w_next_pc;
  logic [BITS-1:0] w_pc_inc;
  logic [BITS-1:0] w_pc_rel;
  logic            w_retire;
  logic            w_ir_we;
  logic            w_exec_en;
  logic            w_halted;
  logic            w_wrap;

  // Both sums wrap silently at 2^BITS; the offset is two's complement so plain addition suffices.
  assign w_pc_inc = bus.pc + ONE;
  assign w_pc_rel = bus.pc + bus.target;

  // Next-state, next-pc and per-state strobes, all combinational from state and inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_next_pc   = bus.pc;
    w_retire    = 1'b0;
    w_ir_we     = 1'b0;
    w_exec_en   = 1'b0;
    w_halted    = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_next_pc   = RESET_PC;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_ir_we = 1'b1;
        if (bus.stall) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_exec_en = 1'b1;
        if (bus.stall) begin
          w_state_nxt = ST_EXEC;
        end else if (bus.halt) begin
          w_state_nxt = ST_HALT;
          w_retire    = 1'b1;
        end else if (bus.jump) begin
          w_state_nxt = ST_FETCH;
          w_retire    = 1'b1;
          if (bus.jump_abs) begin
            w_next_pc = bus.target;
          end else begin
            w_next_pc = w_pc_rel;
          end
        end else begin
          w_state_nxt = ST_FETCH;
          w_retire    = 1'b1;
          w_next_pc   = w_pc_inc;
          w_wrap      = &bus.pc;
        end
      end
      ST_HALT: begin
        w_halted    = 1'b1;
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_next_pc   = RESET_PC;
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  // State register and retired-instruction counter, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_retired <= {BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) begin
        r_retired <= r_retired + ONE;
      end
    end
  end

  assign bus.next_pc = w_next_pc;
  assign bus.ir_we   = w_ir_we;
  assign bus.exec_en = w_exec_en;
  assign bus.halted  = w_halted;
  assign bus.wrap    = w_wrap;
  assign bus.retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;
  localparam int BITS = 8;
  localparam logic [7:0] RST_PC = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] pc_q;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.BITS(BITS)) bus ();

  pc_sequencer #(.BITS(BITS), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External pc register: captures next_pc every edge, no reset.
  always @(posedge clk) pc_q <= bus.next_pc;
  assign bus.pc = pc_q;

  // ---------------- behavioural model ----------------
  // phase: 0 = reset, 1 = fetch, 2 = execute, 3 = halted
  int       m_phase = 0;
  int       m_count = 0;
  int       m_pc = 0;
  bit       m_pc_known = 1'b0;
  int       e_next;
  bit       e_ir, e_ex, e_hl, e_wr;

  always_comb begin
    e_next = m_pc;
    e_ir = 1'b0; e_ex = 1'b0; e_hl = 1'b0; e_wr = 1'b0;
    if (m_phase == 0) e_next = int'(RST_PC);
    if (m_phase == 1) e_ir = 1'b1;
    if (m_phase == 3) e_hl = 1'b1;
    if (m_phase == 2) begin
      e_ex = 1'b1;
      if (!bus.stall && !bus.halt) begin
        if (bus.jump && bus.jump_abs) e_next = int'(bus.target);
        else if (bus.jump)            e_next = (m_pc + int'(bus.target)) % 256;
        else begin
          e_next = (m_pc + 1) % 256;
          e_wr   = (m_pc == 255);
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_count <= 0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1 && !bus.stall) begin
      m_phase <= 2;
    end else if (m_phase == 2 && !bus.stall) begin
      m_count <= (m_count + 1) % 256;
      m_phase <= bus.halt ? 3 : 1;
    end
  end

  always @(posedge clk) begin
    m_pc <= e_next;
    if (m_phase == 0) m_pc_known <= 1'b1;
  end

  // Single per-cycle compare of every output (and the pc register once it is defined).
  always @(negedge clk) begin
    checks++;
    if (bus.next_pc !== e_next[7:0] || bus.ir_we !== e_ir || bus.exec_en !== e_ex ||
        bus.halted !== e_hl || bus.wrap !== e_wr || bus.retired !== m_count[7:0] ||
        (m_pc_known && pc_q !== m_pc[7:0])) begin
      errors++;
      $display("FAIL cycle t=%0t: got next_pc=%h ir_we=%b exec_en=%b halted=%b wrap=%b retired=%h pc=%h; want next_pc=%h ir_we=%b exec_en=%b halted=%b wrap=%b retired=%h pc=%h",
               $time, bus.next_pc, bus.ir_we, bus.exec_en, bus.halted, bus.wrap, bus.retired, pc_q,
               e_next[7:0], e_ir, e_ex, e_hl, e_wr, m_count[7:0], m_pc[7:0]);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic h, input logic j, input logic a, input logic [7:0] t);
    bus.stall = s; bus.halt = h; bus.jump = j; bus.jump_abs = a; bus.target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 1'b0; bus.halt = 1'b0; bus.jump = 1'b0; bus.jump_abs = 1'b0; bus.target = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_next_pc", {24'h0, bus.next_pc}, 32'h0);
    chk("reset_strobes", {28'h0, bus.ir_we, bus.exec_en, bus.halted, bus.wrap}, 32'h0);
    rst = 1'b0;

    // Three straight-line instructions from RESET_PC.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("first_fetch_pc", {24'h0, pc_q}, 32'h0);
    chk("first_fetch_ir_we", {31'h0, bus.ir_we}, 32'h1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("seq3_pc", {24'h0, pc_q}, 32'h3);
    chk("seq3_retired", {24'h0, bus.retired}, 32'h3);

    // Wrap across 255 -> 0.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFE);
    chk("jump_to_254", {24'h0, pc_q}, 32'hFE);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.stall = 1'b0; bus.halt = 1'b0; bus.jump = 1'b0;
    #3;
    chk("no_wrap_at_254", {31'h0, bus.wrap}, 32'h0);
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #3;
    chk("wrap_at_255", {31'h0, bus.wrap}, 32'h1);
    @(posedge clk); #1;
    chk("pc_wrapped", {24'h0, pc_q}, 32'h0);
    chk("retired_after_wrap", {24'h0, bus.retired}, 32'h6);

    // Absolute then relative jumps from 0x10.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hA0);
    chk("abs_jump", {24'h0, pc_q}, 32'hA0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
    chk("rel_jump", {24'h0, pc_q}, 32'h0E);

    // Stalls: 3 in FETCH, 2 in EXEC -> 7-cycle instruction.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stall_pc_held", {24'h0, pc_q}, 32'h0E);
    chk("stall_no_retire", {24'h0, bus.retired}, 32'd10);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stall_done_pc", {24'h0, pc_q}, 32'h0F);
    chk("stall_done_retired", {24'h0, bus.retired}, 32'd11);

    // Halt beats jump; HALT ignores everything.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h20);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      chk("halt_pc_held", {23'h0, bus.halted, pc_q}, {23'h0, 1'b1, 8'h20});
    end
    chk("halt_retired", {24'h0, bus.retired}, 32'd13);

    // Reset while halted.
    rst = 1'b1;
    #2;
    chk("rst_in_halt_outputs", {22'h0, bus.halted, bus.exec_en, bus.next_pc}, 32'h0);
    chk("rst_in_halt_retired", {24'h0, bus.retired}, 32'h0);
    @(posedge clk); #1;
    chk("rst_in_halt_pc", {24'h0, pc_q}, {24'h0, RST_PC});
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("pre_midexec_retired", {24'h0, bus.retired}, 32'h1);

    // Reset mid-EXEC.
    bus.jump = 1'b1; bus.jump_abs = 1'b1; bus.target = 8'h77;
    rst = 1'b1;
    #2;
    chk("rst_mid_exec_outputs", {22'h0, bus.exec_en, bus.ir_we, bus.next_pc}, 32'h0);
    chk("rst_mid_exec_retired", {24'h0, bus.retired}, 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_exec_pc", {24'h0, pc_q}, {24'h0, RST_PC});
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("resume_pc", {24'h0, pc_q}, 32'h1);
    chk("resume_retired", {24'h0, bus.retired}, 32'h1);

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0 || (m_phase == 3 && $urandom_range(0, 9) == 0)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
      end
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
